// File: rtl/cv32e40p_pkg.sv
// Shared types for the EX/WB pipeline register and its TMR helpers.
package cv32e40p_pkg;

    localparam int unsigned EX_WB_PAYLOAD_W = 40;
    localparam int unsigned TMR_COPIES      = 3;

    // Bit layout, LSB first: we[0], waddr[6:1], data_we[7], pc[39:8]
    typedef struct packed {
        logic [31:0] pc;
        logic        data_we;
        logic [5:0]  waddr;
        logic        we;
    } ex_wb_payload_t;

endpackage

// File: rtl/cv32e40p_tmr_voter.sv
// Bitwise 2-of-3 majority voter with a copy-disagreement flag.
module cv32e40p_tmr_voter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] voted_o,
    output logic             mismatch_o
);

    // Majority per bit; any bit where a copy disagrees with the others raises mismatch.
    always_comb begin
        voted_o    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
        mismatch_o = |((a_i ^ b_i) | (a_i ^ c_i));
    end

endmodule

// File: rtl/cv32e40p_ex_wb_pipeline_tmr.sv
// EX/WB write-back control register held in three copies with majority vote,
// optional scrubbing, saturating mismatch counter and sticky fault flag.
module cv32e40p_ex_wb_pipeline_tmr
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ERR_CNT_WIDTH = 8,
    parameter int unsigned ERR_THRESH    = 16,
    parameter bit          SCRUB_EN      = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ex_valid_i,
    input  logic                        wb_ready_i,
    input  logic                        flush_i,
    input  logic                        regfile_we_ex_i,
    input  logic [5:0]                  regfile_waddr_ex_i,
    input  logic                        data_we_ex_i,
    input  logic [31:0]                 pc_ex_i,
    output logic                        regfile_we_wb_o,
    output logic [5:0]                  regfile_waddr_wb_o,
    output logic                        data_we_wb_o,
    output logic [31:0]                 pc_wb_o,
    output logic                        mismatch_o,
    output logic [ERR_CNT_WIDTH-1:0]    err_cnt_o,
    output logic                        fault_o,
    input  logic                        err_clr_i,
    input  logic                        inj_en_i,
    input  logic [1:0]                  inj_copy_i,
    input  logic [EX_WB_PAYLOAD_W-1:0]  inj_mask_i
);

    localparam logic [ERR_CNT_WIDTH-1:0] THRESH_C = ERR_CNT_WIDTH'(ERR_THRESH);

    ex_wb_payload_t                copy_q [TMR_COPIES];
    ex_wb_payload_t                copy_d [TMR_COPIES];
    logic [EX_WB_PAYLOAD_W-1:0]    voted;
    ex_wb_payload_t                voted_s;
    logic                          mismatch;
    logic [ERR_CNT_WIDTH-1:0]      err_cnt_q;
    logic [ERR_CNT_WIDTH-1:0]      err_cnt_d;
    logic                          fault_q;
    logic                          fault_d;

    cv32e40p_tmr_voter #(
        .WIDTH (EX_WB_PAYLOAD_W)
    ) u_voter (
        .a_i        (copy_q[0]),
        .b_i        (copy_q[1]),
        .c_i        (copy_q[2]),
        .voted_o    (voted),
        .mismatch_o (mismatch)
    );

    assign voted_s = voted;

    // Next value per copy: hold/scrub base, then flush > capture > consume, then injection.
    always_comb begin
        for (int i = 0; i < int'(TMR_COPIES); i++) begin
            copy_d[i] = SCRUB_EN ? voted_s : copy_q[i];
            if (flush_i) begin
                copy_d[i].we = 1'b0;
            end else if (ex_valid_i) begin
                copy_d[i].we = regfile_we_ex_i;
                if (regfile_we_ex_i) begin
                    copy_d[i].waddr   = regfile_waddr_ex_i;
                    copy_d[i].data_we = data_we_ex_i;
                    copy_d[i].pc      = pc_ex_i;
                end
            end else if (wb_ready_i) begin
                copy_d[i].we = 1'b0;
            end
            if (inj_en_i && (inj_copy_i == 2'(i))) begin
                copy_d[i] = copy_d[i] ^ inj_mask_i;
            end
        end
    end

    // Three payload copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TMR_COPIES); i++) begin
                copy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(TMR_COPIES); i++) begin
                copy_q[i] <= copy_d[i];
            end
        end
    end

    // Saturating mismatch-cycle counter and sticky threshold flag; clear has priority.
    always_comb begin
        err_cnt_d = err_cnt_q;
        fault_d   = fault_q;
        if (err_clr_i) begin
            err_cnt_d = '0;
            fault_d   = 1'b0;
        end else begin
            if (mismatch && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_cnt_d >= THRESH_C) begin
                fault_d = 1'b1;
            end
        end
    end

    // Counter and fault flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            fault_q   <= fault_d;
        end
    end

    assign regfile_we_wb_o    = voted_s.we;
    assign regfile_waddr_wb_o = voted_s.waddr;
    assign data_we_wb_o       = voted_s.data_we;
    assign pc_wb_o            = voted_s.pc;
    assign mismatch_o         = mismatch;
    assign err_cnt_o          = err_cnt_q;
    assign fault_o            = fault_q;

endmodule

// File: tb/tb_cv32e40p_ex_wb_pipeline_tmr.sv
// Directed bench: a scrubbing instance (u_dut_a) and a non-scrubbing
// instance (u_dut_b) share stimulus; injection enable is per instance.
module tb_cv32e40p_ex_wb_pipeline_tmr;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        wb_ready;
    logic        flush;
    logic        we_ex;
    logic [5:0]  waddr_ex;
    logic        data_we_ex;
    logic [31:0] pc_ex;
    logic        err_clr;
    logic        inj_en_a;
    logic        inj_en_b;
    logic [1:0]  inj_copy;
    logic [39:0] inj_mask;

    logic        we_a,  we_b;
    logic [5:0]  waddr_a, waddr_b;
    logic        dwe_a, dwe_b;
    logic [31:0] pc_a,  pc_b;
    logic        mm_a,  mm_b;
    logic [7:0]  cnt_a, cnt_b;
    logic        flt_a, flt_b;

    int n_chk  = 0;
    int n_pass = 0;

    cv32e40p_ex_wb_pipeline_tmr #(
        .ERR_CNT_WIDTH (8),
        .ERR_THRESH    (16),
        .SCRUB_EN      (1'b1)
    ) u_dut_a (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_valid_i         (ex_valid),
        .wb_ready_i         (wb_ready),
        .flush_i            (flush),
        .regfile_we_ex_i    (we_ex),
        .regfile_waddr_ex_i (waddr_ex),
        .data_we_ex_i       (data_we_ex),
        .pc_ex_i            (pc_ex),
        .regfile_we_wb_o    (we_a),
        .regfile_waddr_wb_o (waddr_a),
        .data_we_wb_o       (dwe_a),
        .pc_wb_o            (pc_a),
        .mismatch_o         (mm_a),
        .err_cnt_o          (cnt_a),
        .fault_o            (flt_a),
        .err_clr_i          (err_clr),
        .inj_en_i           (inj_en_a),
        .inj_copy_i         (inj_copy),
        .inj_mask_i         (inj_mask)
    );

    cv32e40p_ex_wb_pipeline_tmr #(
        .ERR_CNT_WIDTH (8),
        .ERR_THRESH    (16),
        .SCRUB_EN      (1'b0)
    ) u_dut_b (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_valid_i         (ex_valid),
        .wb_ready_i         (wb_ready),
        .flush_i            (flush),
        .regfile_we_ex_i    (we_ex),
        .regfile_waddr_ex_i (waddr_ex),
        .data_we_ex_i       (data_we_ex),
        .pc_ex_i            (pc_ex),
        .regfile_we_wb_o    (we_b),
        .regfile_waddr_wb_o (waddr_b),
        .data_we_wb_o       (dwe_b),
        .pc_wb_o            (pc_b),
        .mismatch_o         (mm_b),
        .err_cnt_o          (cnt_b),
        .fault_o            (flt_b),
        .err_clr_i          (err_clr),
        .inj_en_i           (inj_en_b),
        .inj_copy_i         (inj_copy),
        .inj_mask_i         (inj_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic we, input logic [5:0] wa, input logic dwe, input logic [31:0] pc);
        ex_valid   = 1'b1;
        we_ex      = we;
        waddr_ex   = wa;
        data_we_ex = dwe;
        pc_ex      = pc;
        tick();
        ex_valid   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        wb_ready   = 1'b0;
        flush      = 1'b0;
        we_ex      = 1'b0;
        waddr_ex   = '0;
        data_we_ex = 1'b0;
        pc_ex      = '0;
        err_clr    = 1'b0;
        inj_en_a   = 1'b0;
        inj_en_b   = 1'b0;
        inj_copy   = 2'd3;
        inj_mask   = '0;

        #12 rst_n = 1'b1;
        tick();
        chk("rst_we",    40'(we_a),    40'h0);
        chk("rst_pc",    40'(pc_a),    40'h0);
        chk("rst_mm",    40'(mm_a),    40'h0);
        chk("rst_cnt",   40'(cnt_a),   40'h0);
        chk("rst_fault", 40'(flt_a),   40'h0);

        // Capture with one-cycle latency, then WB consumes.
        capture(1'b1, 6'h0A, 1'b1, 32'h0000_1000);
        chk("cap_we",    40'(we_a),    40'h1);
        chk("cap_waddr", 40'(waddr_a), 40'h0A);
        chk("cap_dwe",   40'(dwe_a),   40'h1);
        chk("cap_pc",    40'(pc_a),    40'h1000);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("rdy_we",    40'(we_a),    40'h0);
        chk("rdy_waddr", 40'(waddr_a), 40'h0A);

        // Single-copy upset on waddr bit0, scrubbed on the following edge.
        inj_copy = 2'd1;
        inj_mask = 40'h2;
        inj_en_a = 1'b1;
        tick();
        inj_en_a = 1'b0;
        chk("inj_waddr", 40'(waddr_a), 40'h0A);
        chk("inj_mm",    40'(mm_a),    40'h1);
        chk("inj_cnt0",  40'(cnt_a),   40'h0);
        tick();
        chk("scrub_mm",    40'(mm_a),    40'h0);
        chk("scrub_cnt",   40'(cnt_a),   40'h1);
        chk("scrub_waddr", 40'(waddr_a), 40'h0A);
        tick();
        chk("scrub_cnt_hold", 40'(cnt_a), 40'h1);

        // Injection with inj_copy=3 has no effect.
        inj_copy = 2'd3;
        inj_mask = 40'hFF_FFFF_FFFF;
        inj_en_a = 1'b1;
        tick();
        inj_en_a = 1'b0;
        chk("inj3_mm", 40'(mm_a), 40'h0);

        // Flush beats a simultaneous capture; ex_valid with we_ex=0 holds payload.
        capture(1'b1, 6'h15, 1'b0, 32'h0000_2000);
        chk("ld_waddr", 40'(waddr_a), 40'h15);
        flush = 1'b1;
        capture(1'b1, 6'h3F, 1'b1, 32'hDEAD_BEEC);
        flush = 1'b0;
        chk("flush_we",    40'(we_a),    40'h0);
        chk("flush_waddr", 40'(waddr_a), 40'h15);
        chk("flush_pc",    40'(pc_a),    40'h2000);
        chk("flush_dwe",   40'(dwe_a),   40'h0);
        capture(1'b0, 6'h01, 1'b1, 32'h0000_3000);
        chk("nowe_we",    40'(we_a),    40'h0);
        chk("nowe_waddr", 40'(waddr_a), 40'h15);
        chk("nowe_pc",    40'(pc_b),    40'h2000);

        // Asynchronous reset while a write is pending in WB.
        capture(1'b1, 6'h07, 1'b1, 32'h0000_4000);
        chk("pre_rst_we", 40'(we_a), 40'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",    40'(we_a),    40'h0);
        chk("arst_waddr", 40'(waddr_a), 40'h0);
        chk("arst_pc",    40'(pc_a),    40'h0);
        chk("arst_dwe",   40'(dwe_a),   40'h0);
        chk("arst_cnt",   40'(cnt_a),   40'h0);
        #1 rst_n = 1'b1;
        we_ex    = 1'b1;
        waddr_ex = 6'h2A;
        pc_ex    = 32'h0000_5000;
        tick();
        tick();
        tick();
        chk("post_rst_we",    40'(we_a),    40'h0);
        chk("post_rst_waddr", 40'(waddr_a), 40'h0);

        // Non-scrubbing instance: one upset in copy 2 persists.
        inj_copy = 2'd2;
        inj_mask = 40'h1;
        inj_en_b = 1'b1;
        tick();
        inj_en_b = 1'b0;
        chk("ns_mm",  40'(mm_b),  40'h1);
        chk("ns_cnt", 40'(cnt_b), 40'h0);
        chk("ns_we",  40'(we_b),  40'h0);
        for (int k = 0; k < 15; k++) tick();
        chk("ns_cnt15",   40'(cnt_b), 40'd15);
        chk("ns_fault15", 40'(flt_b), 40'h0);
        tick();
        chk("ns_cnt16",   40'(cnt_b), 40'd16);
        chk("ns_fault16", 40'(flt_b), 40'h1);
        for (int k = 0; k < 284; k++) tick();
        chk("ns_sat",      40'(cnt_b), 40'd255);
        chk("ns_sat_flt",  40'(flt_b), 40'h1);
        chk("ns_sat_mm",   40'(mm_b),  40'h1);
        chk("ns_sat_we",   40'(we_b),  40'h0);
        chk("a_quiet_cnt", 40'(cnt_a), 40'h0);

        // Clear on an edge with mismatch still active.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_cnt",   40'(cnt_b), 40'h0);
        chk("clr_fault", 40'(flt_b), 40'h0);
        tick();
        chk("clr_recount", 40'(cnt_b), 40'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
